// File: rtl/irq_pkg.sv
// Shared definitions for the 6809 interrupt vector acknowledge block:
// vector identifiers, vector fetch addresses and mask-state encodings.
package irq_pkg;

    // Identifier of the last completed vector fetch
    typedef enum logic [2:0] {
        VEC_RESET = 3'd0,
        VEC_NMI   = 3'd1,
        VEC_SWI   = 3'd2,
        VEC_IRQ   = 3'd3,
        VEC_FIRQ  = 3'd4,
        VEC_SWI2  = 3'd5,
        VEC_SWI3  = 3'd6,
        VEC_NONE  = 3'd7
    } vec_id_t;

    // Vector fetch FSM
    typedef enum logic {
        VS_IDLE = 1'b0,
        VS_HI   = 1'b1
    } vec_state_t;

    // Mask control state; the encoding is also exposed through the SAM
    // register read-back, so the values are fixed.
    typedef enum logic [1:0] {
        MASK_UNMASKED = 2'd0,
        MASK_MASKED   = 2'd1,
        MASK_LOCKOUT  = 2'd2
    } mask_state_t;

    // High-byte addresses of the vector table
    localparam logic [15:0] VEC_ADDR_BASE  = 16'hFFF0;
    localparam logic [15:0] VEC_ADDR_SWI3  = 16'hFFF2;
    localparam logic [15:0] VEC_ADDR_SWI2  = 16'hFFF4;
    localparam logic [15:0] VEC_ADDR_FIRQ  = 16'hFFF6;
    localparam logic [15:0] VEC_ADDR_IRQ   = 16'hFFF8;
    localparam logic [15:0] VEC_ADDR_SWI   = 16'hFFFA;
    localparam logic [15:0] VEC_ADDR_NMI   = 16'hFFFC;
    localparam logic [15:0] VEC_ADDR_RESET = 16'hFFFE;

    // Map the low nibble of a high-byte vector address to its identifier
    function automatic vec_id_t vec_decode(input logic [3:0] lo);
        vec_id_t id;
        case (lo)
            VEC_ADDR_RESET[3:0]: id = VEC_RESET;
            VEC_ADDR_NMI[3:0]:   id = VEC_NMI;
            VEC_ADDR_SWI[3:0]:   id = VEC_SWI;
            VEC_ADDR_IRQ[3:0]:   id = VEC_IRQ;
            VEC_ADDR_FIRQ[3:0]:  id = VEC_FIRQ;
            VEC_ADDR_SWI2[3:0]:  id = VEC_SWI2;
            VEC_ADDR_SWI3[3:0]:  id = VEC_SWI3;
            default:             id = VEC_NONE;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/irq_vector_ack_if.sv
// CPU bus sample, SAM mask request and acknowledge outputs of irq_vector_ack.
interface irq_vector_ack_if;
    logic        cpu_cycle;
    logic        ba;
    logic        bs;
    logic [15:0] addr;
    logic        rnw;
    logic        mask_req;
    logic        mask;
    logic        ack_nmi;
    logic        ack_irq;
    logic        ack_firq;
    logic [2:0]  vec_id;
    logic        vec_busy;
    logic        vec_err;
    logic        mask_timeout;

    modport slave (
        input  cpu_cycle, ba, bs, addr, rnw, mask_req,
        output mask, ack_nmi, ack_irq, ack_firq, vec_id, vec_busy, vec_err, mask_timeout
    );

    modport master (
        output cpu_cycle, ba, bs, addr, rnw, mask_req,
        input  mask, ack_nmi, ack_irq, ack_firq, vec_id, vec_busy, vec_err, mask_timeout
    );
endinterface

// File: rtl/mask_hold_timer.sv
// Bounds how long the interrupt mask may stay asserted: counts CPU cycles
// spent masked, flags expiry, and keeps a sticky timeout flag.
module mask_hold_timer #(
    parameter int MASK_MAX = 4096,
    parameter int CNT_W    = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_cycle,
    input  logic masked,
    input  logic enter,
    input  logic mask_req,
    output logic expire,
    output logic mask_timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MASK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MASK_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             req_q, req_d;

    // Expiry is the strobe that brings the count up to MASK_MAX
    assign expire       = masked && cpu_cycle && (cnt_q == CNT_LAST);
    assign mask_timeout = timeout_q;

    // Counter clears on entry to MASKED and saturates; flag is sticky until mask_req rises
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        req_d     = mask_req;
        if (enter) begin
            cnt_d = '0;
        end else if (masked && cpu_cycle && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (mask_req && !req_q) begin
            timeout_d = 1'b0;
        end
        if (expire) begin
            timeout_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            req_q     <= req_d;
        end
    end

endmodule

// File: rtl/irq_vector_ack.sv
// 6809 interrupt vector fetch detector with acknowledge pulses, plus the
// interrupt mask request state machine that feeds the SAMx4 masking stage.
module irq_vector_ack
    import irq_pkg::*;
#(
    parameter int MASK_MAX = 4096,
    parameter int CNT_W    = 13
) (
    input  logic             clk,
    input  logic             rst,
    irq_vector_ack_if.slave  bus
);
    vec_state_t  vec_state_q, vec_state_d;
    logic [2:0]  vec_lat_q, vec_lat_d;
    vec_id_t     vec_id_q, vec_id_d;
    logic        ack_nmi_q, ack_nmi_d;
    logic        ack_irq_q, ack_irq_d;
    logic        ack_firq_q, ack_firq_d;
    logic        vec_err_q, vec_err_d;
    mask_state_t mask_state_q, mask_state_d;

    logic        vec_qual;
    logic        lo_match;
    vec_id_t     dec_id;
    logic        vec_idle_nxt;
    logic        mask_enter;
    logic        mask_expire;
    logic        mask_timeout;

    // A bus sample is a vector read only on the strobe, with BA=0/BS=1, in FFF2-FFFF
    assign vec_qual = bus.cpu_cycle && !bus.ba && bus.bs && bus.rnw &&
                      (bus.addr[15:4] == VEC_ADDR_BASE[15:4]) && (bus.addr[3:1] != 3'd0);
    assign lo_match = (bus.addr[3:0] == {vec_lat_q, 1'b1});
    assign dec_id   = vec_decode({vec_lat_q, 1'b0});

    // Vector fetch FSM: pair high and low byte reads and classify the result
    always_comb begin
        vec_state_d = vec_state_q;
        vec_lat_d   = vec_lat_q;
        vec_id_d    = vec_id_q;
        ack_nmi_d   = 1'b0;
        ack_irq_d   = 1'b0;
        ack_firq_d  = 1'b0;
        vec_err_d   = 1'b0;
        case (vec_state_q)
            VS_IDLE: begin
                if (vec_qual) begin
                    if (!bus.addr[0]) begin
                        vec_state_d = VS_HI;
                        vec_lat_d   = bus.addr[3:1];
                    end else begin
                        vec_err_d = 1'b1;
                    end
                end
            end
            VS_HI: begin
                if (bus.cpu_cycle) begin
                    vec_state_d = VS_IDLE;
                    if (vec_qual && lo_match) begin
                        vec_id_d   = dec_id;
                        ack_nmi_d  = (dec_id == VEC_NMI);
                        ack_irq_d  = (dec_id == VEC_IRQ);
                        ack_firq_d = (dec_id == VEC_FIRQ);
                    end else begin
                        vec_err_d = 1'b1;
                    end
                end
            end
            default: vec_state_d = VS_IDLE;
        endcase
    end

    // Mask changes look at the post-edge vector state, so a completing fetch releases them on the same edge
    assign vec_idle_nxt = (vec_state_d == VS_IDLE);

    // Mask control FSM: deferred behind in-flight fetches, forced out by the hold timer
    always_comb begin
        mask_state_d = mask_state_q;
        case (mask_state_q)
            MASK_UNMASKED: begin
                if (bus.mask_req && vec_idle_nxt) begin
                    mask_state_d = MASK_MASKED;
                end
            end
            MASK_MASKED: begin
                if (mask_expire) begin
                    mask_state_d = MASK_LOCKOUT;
                end else if (!bus.mask_req && vec_idle_nxt) begin
                    mask_state_d = MASK_UNMASKED;
                end
            end
            MASK_LOCKOUT: begin
                if (!bus.mask_req) begin
                    mask_state_d = MASK_UNMASKED;
                end
            end
            default: mask_state_d = MASK_UNMASKED;
        endcase
    end

    assign mask_enter = (mask_state_q != MASK_MASKED) && (mask_state_d == MASK_MASKED);

    mask_hold_timer #(
        .MASK_MAX (MASK_MAX),
        .CNT_W    (CNT_W)
    ) u_mask_hold_timer (
        .clk          (clk),
        .rst          (rst),
        .cpu_cycle    (bus.cpu_cycle),
        .masked       (mask_state_q == MASK_MASKED),
        .enter        (mask_enter),
        .mask_req     (bus.mask_req),
        .expire       (mask_expire),
        .mask_timeout (mask_timeout)
    );

    // State and output registers; reset abandons any fetch silently
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_state_q  <= VS_IDLE;
            vec_lat_q    <= 3'd0;
            vec_id_q     <= VEC_NONE;
            ack_nmi_q    <= 1'b0;
            ack_irq_q    <= 1'b0;
            ack_firq_q   <= 1'b0;
            vec_err_q    <= 1'b0;
            mask_state_q <= MASK_UNMASKED;
        end else begin
            vec_state_q  <= vec_state_d;
            vec_lat_q    <= vec_lat_d;
            vec_id_q     <= vec_id_d;
            ack_nmi_q    <= ack_nmi_d;
            ack_irq_q    <= ack_irq_d;
            ack_firq_q   <= ack_firq_d;
            vec_err_q    <= vec_err_d;
            mask_state_q <= mask_state_d;
        end
    end

    assign bus.mask         = (mask_state_q == MASK_MASKED);
    assign bus.ack_nmi      = ack_nmi_q;
    assign bus.ack_irq      = ack_irq_q;
    assign bus.ack_firq     = ack_firq_q;
    assign bus.vec_id       = vec_id_q;
    assign bus.vec_busy     = (vec_state_q == VS_HI);
    assign bus.vec_err      = vec_err_q;
    assign bus.mask_timeout = mask_timeout;

endmodule

// File: tb/tb_irq_vector_ack.sv
// Scoreboard bench for irq_vector_ack: stimulus pushes expected vector
// completions, a negedge monitor pops and compares them.
module tb_irq_vector_ack;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_chk;

    typedef struct packed {
        logic       nmi;
        logic       irq;
        logic       firq;
        logic       err;
        logic [2:0] id;
        logic       mask;
    } exp_t;

    exp_t exp_q[$];

    irq_vector_ack_if bus_if();

    irq_vector_ack #(
        .MASK_MAX (8),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic n, input logic i, input logic f, input logic e,
                        input logic [2:0] id, input logic m);
        exp_t x;
        x.nmi = n; x.irq = i; x.firq = f; x.err = e; x.id = id; x.mask = m;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CPU-cycle sample; between strobes the bus shows a vector-like read that must be ignored
    task automatic strobe(input logic [15:0] a, input logic b_a, input logic b_s, input logic r);
        @(posedge clk);
        #1;
        bus_if.addr      = a;
        bus_if.ba        = b_a;
        bus_if.bs        = b_s;
        bus_if.rnw       = r;
        bus_if.cpu_cycle = 1'b1;
        @(posedge clk);
        #1;
        bus_if.cpu_cycle = 1'b0;
        bus_if.addr      = 16'hFFF8;
        bus_if.ba        = 1'b0;
        bus_if.bs        = 1'b1;
        bus_if.rnw       = 1'b1;
    endtask

    task automatic vstrobe(input logic [15:0] a);
        strobe(a, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: every completion (ack, err, or busy falling) consumes one expected entry
    logic prev_busy;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = bus_if.vec_busy;
        end else begin
            if (bus_if.ack_nmi || bus_if.ack_irq || bus_if.ack_firq || bus_if.vec_err ||
                (prev_busy && !bus_if.vec_busy)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event",
                        {12'h0, bus_if.ack_nmi, bus_if.ack_irq, bus_if.ack_firq, bus_if.vec_err},
                        16'h0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("ack_nmi",  {15'h0, bus_if.ack_nmi},  {15'h0, x.nmi});
                    chk("ack_irq",  {15'h0, bus_if.ack_irq},  {15'h0, x.irq});
                    chk("ack_firq", {15'h0, bus_if.ack_firq}, {15'h0, x.firq});
                    chk("vec_err",  {15'h0, bus_if.vec_err},  {15'h0, x.err});
                    chk("vec_id",   {13'h0, bus_if.vec_id},   {13'h0, x.id});
                    chk("mask_at_event", {15'h0, bus_if.mask}, {15'h0, x.mask});
                end
            end
            prev_busy = bus_if.vec_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_chk  = 0;
        prev_busy = 1'b0;
        rst = 1'b1;
        bus_if.cpu_cycle = 1'b0;
        bus_if.ba        = 1'b1;
        bus_if.bs        = 1'b0;
        bus_if.addr      = 16'h0000;
        bus_if.rnw       = 1'b1;
        bus_if.mask_req  = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        chk("rst_mask",     {15'h0, bus_if.mask},         16'h0);
        chk("rst_vec_id",   {13'h0, bus_if.vec_id},       16'h7);
        chk("rst_busy",     {15'h0, bus_if.vec_busy},     16'h0);
        chk("rst_timeout",  {15'h0, bus_if.mask_timeout}, 16'h0);
        chk("rst_acks",     {13'h0, bus_if.ack_nmi, bus_if.ack_irq, bus_if.ack_firq}, 16'h0);
        chk("rst_err",      {15'h0, bus_if.vec_err},      16'h0);

        // IRQ fetch
        push(0, 1, 0, 0, 3'd3, 0);
        vstrobe(16'hFFF8);
        chk("irq_busy_hi", {15'h0, bus_if.vec_busy}, 16'h1);
        idle(2);
        chk("irq_busy_gap", {15'h0, bus_if.vec_busy}, 16'h1);
        vstrobe(16'hFFF9);
        chk("irq_busy_lo", {15'h0, bus_if.vec_busy}, 16'h0);
        chk("irq_vec_id",  {13'h0, bus_if.vec_id},   16'h3);

        // Broken fetch: low byte is not a vector read
        push(0, 0, 0, 1, 3'd3, 0);
        vstrobe(16'hFFFC);
        strobe(16'h1234, 1'b0, 1'b0, 1'b1);
        chk("broken_vec_id", {13'h0, bus_if.vec_id},   16'h3);
        chk("broken_busy",   {15'h0, bus_if.vec_busy}, 16'h0);

        // Deferred mask behind an in-flight FIRQ fetch
        push(0, 0, 1, 0, 3'd4, 1);
        vstrobe(16'hFFF6);
        bus_if.mask_req = 1'b1;
        idle(3);
        chk("defer_mask_held", {15'h0, bus_if.mask}, 16'h0);
        vstrobe(16'hFFF7);
        chk("defer_mask_set", {15'h0, bus_if.mask}, 16'h1);
        bus_if.mask_req = 1'b0;
        idle(2);
        chk("defer_mask_clr", {15'h0, bus_if.mask}, 16'h0);

        // Hold timeout with MASK_MAX=8
        bus_if.mask_req = 1'b1;
        idle(2);
        chk("to_mask_on", {15'h0, bus_if.mask}, 16'h1);
        for (int k = 1; k <= 10; k++) begin
            strobe(16'h1000, 1'b0, 1'b0, 1'b1);
            chk($sformatf("to_mask_s%0d", k), {15'h0, bus_if.mask}, {15'h0, (k < 8)});
            chk($sformatf("to_flag_s%0d", k), {15'h0, bus_if.mask_timeout}, {15'h0, (k >= 8)});
        end
        bus_if.mask_req = 1'b0;
        idle(2);
        chk("to_unmasked",   {15'h0, bus_if.mask},         16'h0);
        chk("to_sticky",     {15'h0, bus_if.mask_timeout}, 16'h1);
        bus_if.mask_req = 1'b1;
        idle(2);
        chk("to_flag_clear", {15'h0, bus_if.mask_timeout}, 16'h0);
        chk("to_remask",     {15'h0, bus_if.mask},         16'h1);
        bus_if.mask_req = 1'b0;
        idle(2);
        chk("to_release",    {15'h0, bus_if.mask},         16'h0);

        // Reset during HI: held across the low-byte strobe
        vstrobe(16'hFFFA);
        chk("rmid_busy_hi", {15'h0, bus_if.vec_busy}, 16'h1);
        rst = 1'b1;
        vstrobe(16'hFFFB);
        chk("rmid_busy",   {15'h0, bus_if.vec_busy}, 16'h0);
        chk("rmid_vec_id", {13'h0, bus_if.vec_id},   16'h7);
        chk("rmid_err",    {15'h0, bus_if.vec_err},  16'h0);
        rst = 1'b0;
        idle(2);
        chk("rmid_post_id", {13'h0, bus_if.vec_id}, 16'h7);

        // Reset vector and SWI3: no ack pulses
        push(0, 0, 0, 0, 3'd0, 0);
        vstrobe(16'hFFFE);
        vstrobe(16'hFFFF);
        chk("reset_vec_id", {13'h0, bus_if.vec_id}, 16'h0);
        push(0, 0, 0, 0, 3'd6, 0);
        vstrobe(16'hFFF2);
        idle(1);
        vstrobe(16'hFFF3);
        chk("swi3_vec_id", {13'h0, bus_if.vec_id}, 16'h6);

        // NMI fetch
        push(1, 0, 0, 0, 3'd1, 0);
        vstrobe(16'hFFFC);
        vstrobe(16'hFFFD);
        chk("nmi_vec_id", {13'h0, bus_if.vec_id}, 16'h1);

        // Odd address seen in IDLE
        push(0, 0, 0, 1, 3'd1, 0);
        vstrobe(16'hFFF9);
        chk("odd_busy", {15'h0, bus_if.vec_busy}, 16'h0);

        // Wrong low byte after a valid high byte
        push(0, 0, 0, 1, 3'd1, 0);
        vstrobe(16'hFFF8);
        vstrobe(16'hFFFB);
        chk("wrong_lo_id", {13'h0, bus_if.vec_id}, 16'h1);

        // Non-qualified samples: write, FFF0, BA high
        strobe(16'hFFF8, 1'b0, 1'b1, 1'b0);
        chk("write_busy", {15'h0, bus_if.vec_busy}, 16'h0);
        vstrobe(16'hFFF0);
        chk("fff0_busy", {15'h0, bus_if.vec_busy}, 16'h0);
        strobe(16'hFFFC, 1'b1, 1'b1, 1'b1);
        chk("ba_busy", {15'h0, bus_if.vec_busy}, 16'h0);

        idle(4);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_vector_ack.md
# irq_vector_ack

Watches the 6809 status pins (BA/BS) and address bus once per CPU cycle and detects interrupt vector fetches. On each two-byte fetch it decodes which exception was taken and emits a one-clock acknowledge to the interrupt sources on the SAM side. It also owns the interrupt mask request that feeds the SAMx4 interrupt masking stage. Mask changes are deferred until any in-flight vector fetch finishes, and the mask releases itself after a bounded hold time.

## Interface
- MASK_MAX, default 4096: maximum CPU cycles the mask may stay asserted before forced release.
- CNT_W, default 13: width of the mask-hold counter; must satisfy 2^CNT_W > MASK_MAX.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_cycle  in  1  one-clk strobe marking the sample point at the end of each CPU E cycle. BA, BS, addr and rnw are valid when it is high.
- ba  in  1  6809 BA.
- bs  in  1  6809 BS.
- addr  in  16  CPU address.
- rnw  in  1  CPU read/not-write.
- mask_req  in  1  level request from the SAM control register to mask interrupts.
- mask  out  1  mask to the interrupt masking stage; 1 holds nNMI/nIRQ/nFIRQ inactive.
- ack_nmi, ack_irq, ack_firq  out  1 each  one-clk acknowledge pulses.
- vec_id  out  3  last completed vector: 0 reset, 1 NMI, 2 SWI, 3 IRQ, 4 FIRQ, 5 SWI2, 6 SWI3, 7 none.
- vec_busy  out  1  high between the high-byte and low-byte vector fetch.
- vec_err  out  1  one-clk pulse on a malformed fetch.
- mask_timeout  out  1  sticky flag; set on forced release, cleared by rst or by a rising edge of mask_req.

## Operation
- Qualified vector cycle: cpu_cycle=1, ba=0, bs=1, rnw=1, and addr[15:4]=FFF with addr[3:1] ≥ 1. The address range is FFF2–FFFF.
- Vector FSM has two states, IDLE and HI.
  - IDLE → HI on a qualified cycle with addr[0]=0. The block latches addr[3:1] and asserts vec_busy.
  - HI → IDLE on the next cpu_cycle strobe.
    - If that cycle is qualified and addr equals the latched address + 1: pulse the matching ack and update vec_id.
    - Otherwise: pulse vec_err and leave vec_id unchanged.
  - A qualified cycle seen in IDLE with addr[0]=1 pulses vec_err and stays in IDLE.
- Decode of latched addr[3:1]:
  - 7 → reset (0)
  - 6 → NMI (1)
  - 5 → SWI (2)
  - 4 → IRQ (3)
  - 3 → FIRQ (4)
  - 2 → SWI2 (5)
  - 1 → SWI3 (6)
  - Only NMI, IRQ and FIRQ produce ack pulses.
- Mask control has three states: UNMASKED, MASKED and LOCKOUT.
  - UNMASKED → MASKED when mask_req=1 and the vector FSM is IDLE. If the vector FSM is in HI, the transition waits until it returns to IDLE.
  - MASKED → UNMASKED when mask_req=0, deferred in the same way.
  - MASKED → LOCKOUT when the hold counter reaches MASK_MAX. This deasserts mask and sets mask_timeout.
  - LOCKOUT → UNMASKED when mask_req=0.
  - mask = 1 only in MASKED.
- Hold counter:
  - Cleared on entry to MASKED.
  - Increments once per cpu_cycle strobe while in MASKED.
  - Saturates at MASK_MAX.
  - Has no effect in other states.
- Simultaneous events: when a mask change and a vector completion occur on the same clk, the vector completes first and the mask transition applies on that same edge.
- Reset values: vector FSM IDLE, mask state UNMASKED, mask=0, all ack pulses 0, vec_err=0, vec_busy=0, vec_id=7, mask_timeout=0, counter=0. Reset during HI abandons the fetch with no ack and no vec_err.

## Timing
- All outputs are registered.
- An ack pulse is high for exactly one clk, on the clk after the cpu_cycle strobe that samples the low byte.
- vec_busy rises one clk after the high-byte strobe and falls together with the ack or vec_err pulse.
- mask changes one clk after the qualifying condition holds.
- Worst-case mask latency from mask_req is one CPU cycle plus one clk, caused by deferral behind an in-flight fetch.
- Forced release occurs one clk after the MASK_MAX-th counted strobe.
- Inputs are sampled only on cpu_cycle. Bus activity between strobes is ignored.

## Structure
- Shared package irq_pkg holds:
  - the vec_id encodings;
  - the vector address offsets (FFF2–FFFE);
  - the mask-state encodings, also used by the SAM register read-back.
- One natural sub-module: mask_hold_timer, containing the counter, the saturation logic and the timeout flag. The two FSMs stay in the top level.

## Test plan
- IRQ fetch: read strobes at FFF8 then FFF9, both with ba=0, bs=1 → ack_irq pulses for 1 clk, vec_id=3, no other ack.
- Broken fetch: FFFC, then the next strobe at 1234 with ba=0, bs=0 → vec_err pulses, no ack_nmi, vec_id unchanged.
- Deferred mask: mask_req rises between the FFF6 and FFF7 strobes → mask stays 0 until the clk of ack_firq, then 1.
- Timeout with MASK_MAX=8: hold mask_req=1 for 10 strobes → mask falls after the 8th strobe and mask_timeout=1. Dropping mask_req then goes to UNMASKED; re-raising it clears mask_timeout and sets mask again.
- Reset mid-fetch: rst asserted after the FFFA strobe, then the FFFB strobe arrives → no ack, no vec_err, vec_busy=0, vec_id=7.
- Reset vector: FFFE/FFFF fetch → vec_id=0 with no ack pulses, and SWI3 at FFF2/FFF3 → vec_id=6.
